circ_shift_frame_buffer: RTL and testbench
==========================================

Name: circ_shift_frame_buffer

Overview:
- Frame reorder buffer between the polyphase filter bank and the FFT in the M/2 polyphase channelizer.
- Collects frames of fft_size samples.
- Applies the M/2 circular rotation on alternate frames so that FFT bin phases stay coherent at 2x output rate.
- Streams frames out with tlast marking the last sample of each frame.

Parameters:
DATA_WIDTH, 32, sample width (I/Q packed).
FFT_SIZE_WIDTH, 12, width of fft_size port; supports frames up to 2048.

Ports:
clk  input  1  clock
sync_reset  input  1  reset; asynchronous, active-high
s_axis_tvalid  input  1  input sample valid
s_axis_tdata  input  DATA_WIDTH  input sample
s_axis_tlast  input  1  input frame marker (see Optional Feature)
s_axis_tready  output  1  input ready
fft_size  input  FFT_SIZE_WIDTH  frame length N; power of 2, 8..2048
phase  input  11  PFB branch index accompanying each input sample
phase_out  output  11  phase value stored with the sample currently on m_axis
m_axis_tvalid  output  1  output valid
m_axis_tdata  output  DATA_WIDTH  output sample
m_axis_tlast  output  1  last sample of output frame
m_axis_tready  input  1  downstream ready

Behaviour:
- Storage: two banks (ping/pong), 2048 words each of {phase, tdata}.
- Write side:
  - wr_cnt counts 0..N-1 on each s_axis handshake; the sample is written at bank[wr_bank][wr_cnt].
  - At wr_cnt = N-1: the bank is marked full, its rotate flag is set to the current frame parity, parity toggles, wr_bank flips, and wr_cnt returns to 0.
- s_axis_tready = 1 unless the bank selected by wr_bank is still full (both banks occupied).
- Read side:
  - When bank[rd_bank] is full, rd_cnt counts 0..N-1.
  - Read address = rd_cnt if rotate = 0; (rd_cnt + N/2) & (N-1) if rotate = 1.
  - Frame parity: frame 0 after reset is unrotated, frame 1 rotated, alternating thereafter.
- RAM read latency is 1 cycle. Output passes through a 2-entry skid FIFO, so reads advance whenever the FIFO has room. Full throughput of 1 sample/clk is sustained with m_axis_tready held high.
- m_axis_tlast = 1 on the word with rd_cnt = N-1. After that word is read from RAM, bank[rd_bank] is cleared to empty, rd_bank flips, and rd_cnt returns to 0.
- Latency: first input sample to the first output of the same frame is N+2 cycles minimum, since a frame is fully buffered before readout.
- Handshake: standard AXI-Stream.
  - Output data and tlast are held stable while tvalid=1 and tready=0.
  - No combinational path from m_axis_tready to s_axis_tready.
- Simultaneous write of the final sample and read-out completion of the other bank: both take effect in the same cycle; no stall is introduced.
- fft_size is sampled continuously but may change only while sync_reset is high. Behaviour for a non-power-of-2 value is undefined.
- Reset (also mid-frame): counters, bank full flags, parity, wr_bank and rd_bank are cleared to 0; the FIFO is emptied. Partial frames are discarded.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, phase_out=0, s_axis_tready=1 once reset is deasserted.

Optional Feature:
- Macro CIRC_TLAST_RESYNC_EN.
- Defined: an accepted s_axis_tlast forces end-of-frame on that sample. The frame is shortened to wr_cnt+1 valid words; the remaining words read out as 0 to keep N output words. wr_cnt returns to 0 and parity toggles.
- Not defined: s_axis_tlast is ignored and framing is purely counter-based.

Test Plan:
- N=8, continuous input 0..7, tready=1 -> output 0..7, tlast on 7, phase_out equals the phase supplied with each sample.
- N=8, second frame 8..15 -> output 12,13,14,15,8,9,10,11 with tlast on 11; third frame 16..23 unrotated.
- N=2048, 10 back-to-back frames, tready=1 -> no s_axis_tready deassertion after the first frame; alternate frames rotated by 1024.
- m_axis_tready random 50% duty, N=16 -> no data loss or duplication; s_axis_tready drops only when both banks are full; output stable during stalls.
- Assert sync_reset after 5 samples of a frame (N=8), then send 0..7 -> output 0..7 unrotated; no stale data; outputs 0 during reset.
- With CIRC_TLAST_RESYNC_EN, N=8, tlast on 4th sample (0..3) -> output 0,1,2,3,0,0,0,0 with tlast on 8th word; next frame rotated.

Source files
------------

// File: rtl/circ_shift_frame_buffer.sv
// circ_shift_frame_buffer
//   Frame reorder buffer between the polyphase filter bank and the FFT of an
//   M/2 polyphase channelizer. Whole frames of fft_size samples are collected
//   into one of two banks (ping/pong). Frames are read back in order, except
//   that every odd frame is rotated by N/2 so the FFT bin phases stay coherent
//   at the 2x output rate. Output goes through a 2-entry skid FIFO.
//
// Ports:
//   clk, sync_reset                   clock, asynchronous active-high reset
//   s_axis_tvalid/tdata/tlast/tready  input sample stream
//   fft_size                          frame length N (power of 2, 8..2048),
//                                     changed only while sync_reset is high
//   phase                             PFB branch index stored with each sample
//   m_axis_tvalid/tdata/tlast/tready  output frame stream, tlast on word N-1
//   phase_out                         phase stored with the current output word
//
// Build option:
//   CIRC_TLAST_RESYNC_EN  when defined, an accepted s_axis_tlast ends the
//                         current input frame early; the missing words of that
//                         frame read out as zero so every output frame is N long.

module circ_shift_frame_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  input  logic [10:0]               phase,
  output logic [10:0]               phase_out,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);

  localparam int AW = 11;
  localparam int WW = AW + DATA_WIDTH;   // {phase, tdata}
  localparam int FW = WW + 1;            // {tlast, phase, tdata}

  logic [AW-1:0] n_m1;
  logic [AW-1:0] half_n;
  assign n_m1   = AW'(fft_size - 1'b1);
  assign half_n = AW'(fft_size >> 1);

  logic [AW-1:0] wr_cnt_q, rd_cnt_q;
  logic          wr_bank_q, rd_bank_q, parity_q;
  logic [1:0]    full_q, rot_q;
  logic          pend_q, rd_last_q;
  logic [WW-1:0] rd_word_q;
  logic [WW-1:0] mem0 [0:2047];
  logic [WW-1:0] mem1 [0:2047];

  logic [FW-1:0] fifo_q [0:1];
  logic          fifo_wp_q, fifo_rp_q;
  logic [1:0]    fifo_cnt_q;

  logic          wr_en, wr_end, rd_issue, rd_last, pop;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] push_word;

  assign s_axis_tready = ~full_q[wr_bank_q];
  assign wr_en         = s_axis_tvalid & s_axis_tready;

`ifdef CIRC_TLAST_RESYNC_EN
  logic [AW:0] len_q [0:1];
  logic        rd_zero_q;
  assign wr_end    = (wr_cnt_q == n_m1) | s_axis_tlast;
  assign push_word = rd_zero_q ? '0 : rd_word_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign wr_end       = (wr_cnt_q == n_m1);
  assign push_word    = rd_word_q;
`endif

  assign pop     = m_axis_tvalid & m_axis_tready;
  assign rd_last = (rd_cnt_q == n_m1);
  assign rd_addr = rot_q[rd_bank_q] ? ((rd_cnt_q + half_n) & n_m1) : rd_cnt_q;

  // FIFO entries plus the word in flight from the RAM never exceed 2; a pop
  // in this cycle frees a slot for the read issued now, which keeps 1/clk.
  assign rd_issue = full_q[rd_bank_q] &
                    ((({1'b0, fifo_cnt_q} + {2'b00, pend_q}) <= 3'd1) | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank_q) mem1[wr_cnt_q] <= {phase, s_axis_tdata};
      else           mem0[wr_cnt_q] <= {phase, s_axis_tdata};
    end
    if (rd_issue) rd_word_q <= rd_bank_q ? mem1[rd_addr] : mem0[rd_addr];
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      parity_q  <= 1'b0;
      full_q    <= '0;
      rot_q     <= '0;
      pend_q    <= 1'b0;
      rd_last_q <= 1'b0;
`ifdef CIRC_TLAST_RESYNC_EN
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      rd_zero_q <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        if (wr_end) begin
          wr_cnt_q          <= '0;
          full_q[wr_bank_q] <= 1'b1;
          rot_q[wr_bank_q]  <= parity_q;
          parity_q          <= ~parity_q;
          wr_bank_q         <= ~wr_bank_q;
`ifdef CIRC_TLAST_RESYNC_EN
          len_q[wr_bank_q]  <= {1'b0, wr_cnt_q} + 1'b1;
`endif
        end else begin
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
      pend_q <= rd_issue;
      if (rd_issue) begin
        rd_last_q <= rd_last;
`ifdef CIRC_TLAST_RESYNC_EN
        rd_zero_q <= ({1'b0, rd_addr} >= len_q[rd_bank_q]);
`endif
        if (rd_last) begin
          rd_cnt_q          <= '0;
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q         <= ~rd_bank_q;
        end else begin
          rd_cnt_q <= rd_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      if (pend_q) begin
        fifo_q[fifo_wp_q] <= {rd_last_q, push_word};
        fifo_wp_q         <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(pend_q) - 2'(pop);
    end
  end

  // The head entry is never overwritten while it is occupied, so the output
  // stays stable during back-pressure.
  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign {m_axis_tlast, phase_out, m_axis_tdata} = fifo_q[fifo_rp_q];

endmodule

// File: tb/tb_circ_shift_frame_buffer.sv
module tb_circ_shift_frame_buffer;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [11:0] fft_size = 12'd8;
  logic [10:0] phase = '0;
  logic [10:0] phase_out;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] in_data[$];
  logic [10:0] in_phase[$];
  logic        in_last[$];
  logic [31:0] out_data[$];
  logic [10:0] out_phase[$];
  logic        out_last[$];

  circ_shift_frame_buffer dut (
    .clk(clk), .sync_reset(sync_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .fft_size(fft_size), .phase(phase), .phase_out(phase_out),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  task automatic push_in(input logic [31:0] d, input logic [10:0] p, input logic l);
    in_data.push_back(d);
    in_phase.push_back(p);
    in_last.push_back(l);
  endtask

  task automatic do_reset(input logic [11:0] n);
    @(negedge clk);
    sync_reset    = 1'b1;
    fft_size      = n;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    sync_reset = 1'b0;
  endtask

  // Streams the input queue in and collects outputs until the input queue is
  // drained and n_out words have come out, or max_cycles elapse.
  task automatic run_stream(input int n_out, input bit rand_rdy, input int frame_n,
                            input int max_cycles, output int cycles,
                            output int ready_drops, output int stall_errs,
                            output int bank_errs);
    bit          prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic [10:0] pp = '0;
    logic        pl = 1'b0;
    int          in_cnt = 0;
    ready_drops = 0; stall_errs = 0; bank_errs = 0;
    out_data.delete(); out_phase.delete(); out_last.delete();
    for (cycles = 0; cycles < max_cycles; cycles++) begin
      @(negedge clk);
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                         phase_out !== pp || m_axis_tlast !== pl))
        stall_errs++;
      if (in_data.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_data[0];
        phase         = in_phase[0];
        s_axis_tlast  = in_last[0];
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        phase         = '0;
        s_axis_tlast  = 1'b0;
      end
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axis_tvalid && !s_axis_tready) begin
        ready_drops++;
        if (in_cnt / frame_n - out_data.size() / frame_n < 2) bank_errs++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        void'(in_data.pop_front());
        void'(in_phase.pop_front());
        void'(in_last.pop_front());
        in_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_data.push_back(m_axis_tdata);
        out_phase.push_back(phase_out);
        out_last.push_back(m_axis_tlast);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pp = phase_out; pl = m_axis_tlast;
      if (in_data.size() == 0 && out_data.size() >= n_out) begin
        cycles++;
        break;
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    fft_size   = 12'd8;
    repeat (3) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_valid_last got %b%b exp 00", m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (m_axis_tdata !== 32'd0 || phase_out !== 11'd0) begin
      errors++; $display("FAIL reset_data_phase got %h/%h exp 0/0", m_axis_tdata, phase_out);
    end
    sync_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready got %b exp 1", s_axis_tready);
    end
  endtask

  task automatic test_unrotated();
    int cyc, rd, se, be, bad;
    logic [7:0] lm;
    for (int i = 0; i < 8; i++) push_in(i, 11'(100 + i), 1'b0);
    run_stream(8, 1'b0, 8, 200, cyc, rd, se, be);
    checks++;
    if (out_data.size() != 8) begin
      errors++; $display("FAIL unrot_count got %0d exp 8", out_data.size());
    end else begin
      bad = 0; lm = '0;
      for (int i = 0; i < 8; i++) begin
        if (out_data[i] !== 32'(i) || out_phase[i] !== 11'(100 + i)) bad++;
        lm[i] = out_last[i];
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL unrot_data got %0d bad words exp 0", bad);
      end
      checks++;
      if (lm !== 8'h80) begin
        errors++; $display("FAIL unrot_tlast got %h exp 80", lm);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL unrot_extra got valid %b exp 0", m_axis_tvalid);
    end
  endtask

  task automatic test_rotated();
    int cyc, rd, se, be, bad;
    logic [15:0] lm;
    int exp_d[16] = '{12, 13, 14, 15, 8, 9, 10, 11, 16, 17, 18, 19, 20, 21, 22, 23};
    for (int i = 8; i < 24; i++) push_in(i, 11'(100 + i), 1'b0);
    run_stream(16, 1'b0, 8, 300, cyc, rd, se, be);
    checks++;
    if (out_data.size() != 16) begin
      errors++; $display("FAIL rot_count got %0d exp 16", out_data.size());
    end else begin
      bad = 0; lm = '0;
      for (int i = 0; i < 16; i++) begin
        if (out_data[i] !== 32'(exp_d[i]) || out_phase[i] !== 11'(100 + exp_d[i])) bad++;
        lm[i] = out_last[i];
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rot_data got %0d bad words exp 0 (first word %0d exp 12)",
                           bad, out_data[0]);
      end
      checks++;
      if (lm !== 16'h8080) begin
        errors++; $display("FAIL rot_tlast got %h exp 8080", lm);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int cyc, rd, se, be, bad;
    do_reset(12'd8);
    for (int i = 0; i < 5; i++) push_in(50 + i, 11'(50 + i), 1'b0);
    run_stream(0, 1'b0, 8, 50, cyc, rd, se, be);
    sync_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 ||
        m_axis_tlast !== 1'b0 || phase_out !== 11'd0) begin
      errors++; $display("FAIL midrst_outputs got v=%b d=%h l=%b p=%h exp all 0",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast, phase_out);
    end
    sync_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL midrst_tready got %b exp 1", s_axis_tready);
    end
    for (int i = 0; i < 8; i++) push_in(i, 11'(200 + i), 1'b0);
    run_stream(8, 1'b0, 8, 200, cyc, rd, se, be);
    bad = 0;
    for (int i = 0; i < out_data.size() && i < 8; i++)
      if (out_data[i] !== 32'(i) || out_phase[i] !== 11'(200 + i) ||
          out_last[i] !== (i == 7)) bad++;
    checks++;
    if (out_data.size() != 8 || bad != 0) begin
      errors++; $display("FAIL midrst_data got %0d words %0d bad exp 8 words 0 bad",
                         out_data.size(), bad);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_extra got valid %b exp 0", m_axis_tvalid);
    end
  endtask

  task automatic test_backpressure();
    int cyc, rd, se, be, bad, f, j, e;
    do_reset(12'd16);
    for (int k = 0; k < 64; k++) push_in(k, 11'((k * 3) & 2047), 1'b0);
    run_stream(64, 1'b1, 16, 2000, cyc, rd, se, be);
    checks++;
    if (out_data.size() != 64) begin
      errors++; $display("FAIL bp_count got %0d exp 64", out_data.size());
    end
    bad = 0;
    for (int k = 0; k < out_data.size() && k < 64; k++) begin
      f = k / 16; j = k % 16;
      e = (f % 2 == 1) ? f * 16 + ((j + 8) & 15) : k;
      if (out_data[k] !== 32'(e) || out_phase[k] !== 11'((e * 3) & 2047) ||
          out_last[k] !== (j == 15)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_data got %0d bad words exp 0", bad);
    end
    checks++;
    if (se != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable stalls exp 0", se);
    end
    checks++;
    if (be != 0) begin
      errors++; $display("FAIL bp_tready got %0d early deasserts exp 0", be);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, rd, se, be, bad, f, j, e;
    do_reset(12'd2048);
    for (int k = 0; k < 20480; k++) push_in(k, 11'(k & 2047), 1'b0);
    run_stream(20480, 1'b0, 2048, 30000, cyc, rd, se, be);
    checks++;
    if (out_data.size() != 20480) begin
      errors++; $display("FAIL b2b_count got %0d exp 20480", out_data.size());
    end
    bad = 0;
    for (int k = 0; k < out_data.size() && k < 20480; k++) begin
      f = k / 2048; j = k % 2048;
      e = (f % 2 == 1) ? f * 2048 + ((j + 1024) & 2047) : k;
      if (out_data[k] !== 32'(e) || out_phase[k] !== 11'(e & 2047) ||
          out_last[k] !== (j == 2047)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_data got %0d bad words exp 0", bad);
    end
    checks++;
    if (rd != 0) begin
      errors++; $display("FAIL b2b_tready got %0d stall cycles exp 0", rd);
    end
    checks++;
    if (cyc > 22540) begin
      errors++; $display("FAIL b2b_throughput got %0d cycles exp <= 22540", cyc);
    end
  endtask

`ifdef CIRC_TLAST_RESYNC_EN
  task automatic test_tlast_resync();
    int cyc, rd, se, be, bad;
    int exp_d[16] = '{0, 1, 2, 3, 0, 0, 0, 0, 14, 15, 16, 17, 10, 11, 12, 13};
    int exp_p[16] = '{1, 2, 3, 4, 0, 0, 0, 0, 15, 16, 17, 18, 11, 12, 13, 14};
    do_reset(12'd8);
    for (int i = 0; i < 4; i++) push_in(i, 11'(i + 1), i == 3);
    for (int i = 10; i < 18; i++) push_in(i, 11'(i + 1), 1'b0);
    run_stream(16, 1'b0, 8, 300, cyc, rd, se, be);
    bad = 0;
    for (int i = 0; i < out_data.size() && i < 16; i++)
      if (out_data[i] !== 32'(exp_d[i]) || out_phase[i] !== 11'(exp_p[i]) ||
          out_last[i] !== (i == 7 || i == 15)) bad++;
    checks++;
    if (out_data.size() != 16 || bad != 0) begin
      errors++; $display("FAIL resync_data got %0d words %0d bad exp 16 words 0 bad",
                         out_data.size(), bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unrotated();
    test_rotated();
    test_midframe_reset();
    test_backpressure();
    test_back_to_back();
`ifdef CIRC_TLAST_RESYNC_EN
    test_tlast_resync();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
